// File: rtl/fas_freq_analysis.sv
// fas_freq_analysis: finds the largest squared-magnitude bin of a 16-point FFT frame
// with one shared squarer/adder stepped over the captured bins.
module fas_freq_analysis #(
   parameter int NBINS = 16,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fft_valid,
   input  logic [2*DW-1:0]          fft_d0,
   input  logic [2*DW-1:0]          fft_d1,
   input  logic [2*DW-1:0]          fft_d2,
   input  logic [2*DW-1:0]          fft_d3,
   input  logic [2*DW-1:0]          fft_d4,
   input  logic [2*DW-1:0]          fft_d5,
   input  logic [2*DW-1:0]          fft_d6,
   input  logic [2*DW-1:0]          fft_d7,
   input  logic [2*DW-1:0]          fft_d8,
   input  logic [2*DW-1:0]          fft_d9,
   input  logic [2*DW-1:0]          fft_d10,
   input  logic [2*DW-1:0]          fft_d11,
   input  logic [2*DW-1:0]          fft_d12,
   input  logic [2*DW-1:0]          fft_d13,
   input  logic [2*DW-1:0]          fft_d14,
   input  logic [2*DW-1:0]          fft_d15,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(NBINS)-1:0] freq,
   output logic [2*DW-1:0]          max_mag
);
   localparam int IW = $clog2(NBINS);
   typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
   state_t state, state_nxt;
   logic [2*DW-1:0] din [NBINS];
   logic [2*DW-1:0] cap [NBINS];
   logic [IW-1:0] idx, run_idx;
   logic [2*DW-1:0] run_max, mag;
   logic signed [DW-1:0] re, im;
   logic signed [2*DW-1:0] pr, pi;
   assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
   // Squares are non-negative and their sum peaks at 2^31, so an unsigned 32-bit add suffices.
   assign re  = cap[idx][2*DW-1:DW];
   assign im  = cap[idx][DW-1:0];
   assign pr  = re * re;
   assign pi  = im * im;
   assign mag = $unsigned(pr) + $unsigned(pi);
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == IDLE) ? (fft_valid ? SCAN : IDLE) :
                  (state == SCAN) ? ((idx == IW'(NBINS-1)) ? REPORT : SCAN) : IDLE;
   end
   always_comb begin
      busy = (state != IDLE);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NBINS; i++) cap[i] <= '0;
         idx     <= '0;
         run_idx <= '0;
         run_max <= '0;
         freq    <= '0;
         max_mag <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && fft_valid) begin
            for (int i = 0; i < NBINS; i++) cap[i] <= din[i];
            idx     <= '0;
            run_idx <= '0;
            run_max <= '0;
         end
         // Strict compare keeps the lowest index on ties; bin 0 always seeds the max.
         if (state == SCAN) begin
            if (idx == '0 || mag > run_max) begin
               run_max <= mag;
               run_idx <= idx;
            end
            idx <= idx + 1'b1;
         end
         if (state == REPORT) begin
            freq    <= run_idx;
            max_mag <= run_max;
            done    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fas_freq_analysis.sv
// tb_fas_freq_analysis: directed frames checked every cycle against a frame-level model,
// plus literal expectations for each scenario.
module tb_fas_freq_analysis;
   logic clk = 1'b0, rst = 1'b0, fft_valid = 1'b0;
   logic [31:0] d [16];
   logic busy, done;
   logic [3:0] freq;
   logic [31:0] max_mag;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   fas_freq_analysis dut (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
      .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
      .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .busy(busy), .done(done), .freq(freq), .max_mag(max_mag)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Winner of a frame: {index, squared magnitude}, first index wins on ties.
   function automatic logic [35:0] mdl(input logic [31:0] f [16]);
      longint best, m, r, i;
      int bi;
      best = -1;
      bi = 0;
      for (int k = 0; k < 16; k++) begin
         r = longint'($signed(f[k][31:16]));
         i = longint'($signed(f[k][15:0]));
         m = r * r + i * i;
         if (m > best) begin
            best = m;
            bi = k;
         end
      end
      return {4'(bi), 32'(best)};
   endfunction

   // A captured frame is reported 17 edges after capture; frames arriving while pending are lost.
   logic m_pend = 1'b0, m_done = 1'b0, started = 1'b0;
   logic [3:0] m_freq = '0;
   logic [31:0] m_mag = '0;
   logic [35:0] e_res = '0;
   int cyc = 0, t_cap = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      started <= 1'b1;
      if (!rst) begin
         m_pend <= 1'b0;
         m_done <= 1'b0;
         m_freq <= '0;
         m_mag  <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_pend && cyc - t_cap == 17) begin
            m_pend <= 1'b0;
            m_done <= 1'b1;
            m_freq <= e_res[35:32];
            m_mag  <= e_res[31:0];
         end else if (!m_pend && fft_valid) begin
            m_pend <= 1'b1;
            t_cap  <= cyc;
            e_res  <= mdl(d);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("busy", 64'(busy), 64'(m_pend));
         check("done", 64'(done), 64'(m_done));
         check("freq", 64'(freq), 64'(m_freq));
         check("max_mag", 64'(max_mag), 64'(m_mag));
      end
   end

   task automatic frame_clear();
      for (int k = 0; k < 16; k++) d[k] = '0;
   endtask

   task automatic pulse();
      fft_valid = 1'b1;
      @(negedge clk);
      fft_valid = 1'b0;
      for (int k = 0; k < 16; k++) d[k] = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      check("done_seen", 64'(done), 64'd1);
   endtask

   initial begin
      int n, nd;
      frame_clear();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_freq", 64'(freq), 64'd0);
      check("rst_mag", 64'(max_mag), 64'd0);
      nd = 0;
      repeat (50) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("idle_no_done", 64'(nd), 64'd0);

      frame_clear();
      d[5] = 32'h0100_0000;
      check("model_pin_peak", 64'(mdl(d)), 64'({4'd5, 32'h0001_0000}));
      pulse();
      check("busy_after_capture", 64'(busy), 64'd1);
      check("freq_held_at_capture", 64'(freq), 64'd0);
      wait_done(n);
      check("peak_latency", 64'(n), 64'd17);
      check("peak_freq", 64'(freq), 64'd5);
      check("peak_mag", 64'(max_mag), 64'h0001_0000);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);

      frame_clear();
      d[3] = 32'h0010_FFF0;
      d[9] = 32'h0010_FFF0;
      check("model_pin_tie", 64'(mdl(d)), 64'({4'd3, 32'd512}));
      pulse();
      wait_done(n);
      check("tie_freq", 64'(freq), 64'd3);
      check("tie_mag", 64'(max_mag), 64'd512);

      frame_clear();
      pulse();
      wait_done(n);
      check("zero_freq", 64'(freq), 64'd0);
      check("zero_mag", 64'(max_mag), 64'd0);

      frame_clear();
      d[12] = 32'h8000_8000;
      d[1]  = 32'h7FFF_7FFF;
      pulse();
      wait_done(n);
      check("ext_freq", 64'(freq), 64'd12);
      check("ext_mag", 64'(max_mag), 64'h8000_0000);

      frame_clear();
      d[0] = 32'h0001_0001;
      d[5] = 32'h0100_0000;
      pulse();
      repeat (4) @(negedge clk);
      frame_clear();
      d[7] = 32'h7FFF_0000;
      pulse();
      wait_done(n);
      check("drop_latency", 64'(n), 64'd12);
      check("drop_freq", 64'(freq), 64'd5);
      frame_clear();
      d[15] = 32'h0020_0020;
      pulse();
      wait_done(n);
      check("b2b_spacing", 64'(n + 1), 64'd18);
      check("b2b_freq", 64'(freq), 64'd15);
      check("b2b_mag", 64'(max_mag), 64'd2048);

      frame_clear();
      d[4] = 32'h0100_0100;
      pulse();
      repeat (7) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_freq", 64'(freq), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_mag", 64'(max_mag), 64'd0);
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("midrst_no_done", 64'(nd), 64'd0);

      frame_clear();
      d[0] = 32'h0001_0001;
      d[2] = 32'h0030_0000;
      pulse();
      wait_done(n);
      check("after_rst_freq", 64'(freq), 64'd2);
      check("after_rst_mag", 64'(max_mag), 64'h0000_0900);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/fas_freq_analysis.md
Name: fas_freq_analysis

Overview:
- Downstream analysis stage of the FAS datapath.
- Consumes each 16-point FFT frame (fft_valid plus fft_d0..fft_d15) and finds the bin with the largest squared magnitude.
- Reports that bin index on freq, with a one-cycle done strobe.
- Uses one shared squarer/adder, iterated over the 16 bins, so the FFT output registers are released in one cycle.

Parameters:
- NBINS, 16: bins per frame. The index width is log2(NBINS). This block is only required to support the value 16.
- DW, 16: width of each real and imaginary component. Components are signed two's complement, 8 integer + 8 fraction bits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-low (rst==0 at a rising edge resets the block).
- fft_valid  input  1  one-cycle strobe: fft_d0..fft_d15 hold a complete frame.
- fft_d0..fft_d15  input  32 each  bin k: [31:16] real, [15:0] imaginary, both signed.
- busy  output  1  high while a frame is captured and still being scanned.
- done  output  1  one-cycle strobe: freq holds the result for the latest frame.
- freq  output  4  index (0..15) of the maximum-magnitude bin.
- max_mag  output  32  unsigned squared magnitude of the winning bin.

Behaviour:
- Reset (rst==0 at a rising edge), highest priority:
  - state=IDLE, busy=0, done=0, freq=0, max_mag=0.
  - Capture registers and scan index are cleared.
  - An in-flight scan is abandoned and no done is produced.
- States are IDLE, SCAN and REPORT.
- IDLE:
  - If fft_valid=1 at edge E0, all 16 words go into a 16x32 capture buffer, the index goes to 0, the running max is cleared, and the state goes to SCAN.
  - busy goes to 1 from E0.
- SCAN:
  - At edge E(k+1), for k=0..15, compute mag_k = re_k*re_k + im_k*im_k.
  - Each product is signed 16x16 to 32 bits, squared, so it is non-negative. The sum is unsigned 32-bit and cannot overflow: the maximum is 2*2^30 = 2^31.
  - The running max is replaced only if mag_k > running max (strict). Ties keep the lower index. Bin 0 is always loaded at k=0, even if its magnitude is 0.
  - After k=15 (edge E16) the state goes to REPORT.
- REPORT:
  - At edge E17, freq and max_mag are loaded from the running max and index, done=1, busy=0, and the state goes to IDLE.
  - done is therefore high for exactly the cycle after E17, 17 cycles after the capture edge. It then returns to 0.
- freq and max_mag hold their values until the next REPORT or reset. They do not change at capture.
- fft_valid while busy=1 (SCAN or REPORT) is ignored: no capture, and the frame is dropped.
- fft_valid in the cycle done is high is accepted, because the state is IDLE. Back-to-back frames therefore have a minimum spacing of 18 cycles.
- X or Z on the fft_d inputs when fft_valid=0 must not affect any state.
- Pipelining the squarer is allowed only if the done timing (17 cycles after capture) is kept exactly.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> busy=0, done=0, freq=0, max_mag=0. With no fft_valid, done stays 0 for 50 cycles.
- Single peak: bin 5 = 32'h0100_0000, all other bins 0, fft_valid at E0 -> busy=1 from E0. done=1 for one cycle after E17, with freq=5 and max_mag=32'h0001_0000.
- Tie and all-zero:
  - Bins 3 and 9 = 32'h0010_FFF0, others 0 -> freq=3.
  - Next frame all zeros -> freq=0, max_mag=0.
- Extremes: bin 12 = 32'h8000_8000, bin 1 = 32'h7FFF_7FFF -> freq=12, max_mag=32'h8000_0000. Confirms there is no overflow and that negative components are handled as signed.
- Dropped frame and back-to-back:
  - Assert fft_valid again at E5 (peak at bin 7) -> ignored; the first result (freq=5) is reported.
  - A frame with its peak at bin 15, asserted in the done cycle, is captured -> second done with freq=15 exactly 18 cycles after the first.
- Reset mid-scan: drive rst=0 at E8 of a scan -> no done pulse, freq=0. A new frame afterwards with its peak at bin 2 -> freq=2.
